// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - register file access bus: write port, dual read port, clear request, ready
//
// Signals:
//   clr        master->slave  request a full clear sweep
//   rd         master->slave  write address
//   write_data master->slave  write data
//   w_en       master->slave  write enable
//   r1, r2     master->slave  read port addresses
//   r_en       master->slave  read enable for both ports
//   r1_read    slave->master  registered port 1 data
//   r2_read    slave->master  registered port 2 data
//   ready      slave->master  array initialised, accepting reads/writes
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic              w_en;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic              r_en;
    logic [DATA_W-1:0] r1_read;
    logic [DATA_W-1:0] r2_read;
    logic              ready;

    modport master (
        output clr, rd, write_data, w_en, r1, r2, r_en,
        input  r1_read, r2_read, ready
    );

    modport slave (
        input  clr, rd, write_data, w_en, r1, r2, r_en,
        output r1_read, r2_read, ready
    );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with zero register, bypass and clear sweep
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of regfile_param_if (clr, rd, write_data, w_en,
//               r1, r2, r_en in; r1_read, r2_read, ready out, all registered)
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_r1_read;
    logic [DATA_W-1:0] r_r2_read;

    // Storage carries no reset so it can map onto distributed RAM; the sweep
    // engine is what brings it to a known state.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_r1_val;
    logic [DATA_W-1:0] w_r2_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == RUN);
        end
    end

    // Next state plus the single shared memory write port: the sweep and
    // normal writes never coincide, so one port serves both.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt;
        w_mem_data  = '0;
        w_rd_en     = 1'b0;
        case (r_state)
            SWEEP: begin
                w_mem_we = 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    // Clear wins over the same cycle's read and write.
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_mem_we   = bus.w_en && !(ZERO_REG && (bus.rd == '0));
                    w_mem_addr = bus.rd;
                    w_mem_data = bus.write_data;
                    w_rd_en    = bus.r_en;
                end
            end
            default: begin
                w_state_nxt = SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Per-port operand resolution; ports are independent, so both may hit
    // the same entry or the write address with no interaction.
    always_comb begin
        w_r1_val = r_mem[bus.r1];
        if (ZERO_REG && (bus.r1 == '0)) begin
            w_r1_val = '0;
        end else if (BYPASS && bus.w_en && (bus.rd == bus.r1)) begin
            w_r1_val = bus.write_data;
        end
    end

    always_comb begin
        w_r2_val = r_mem[bus.r2];
        if (ZERO_REG && (bus.r2 == '0)) begin
            w_r2_val = '0;
        end else if (BYPASS && bus.w_en && (bus.rd == bus.r2)) begin
            w_r2_val = bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1_read <= '0;
            r_r2_read <= '0;
        end else if (w_rd_en) begin
            r_r1_read <= w_r1_val;
            r_r2_read <= w_r2_val;
        end
    end

    assign bus.r1_read = r_r1_read;
    assign bus.r2_read = r_r2_read;
    assign bus.ready   = r_ready;
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param, bypass and non-bypass instances
module tb_regfile_param;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();
    regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_n ();

    assign if_n.clr        = if_b.clr;
    assign if_n.rd         = if_b.rd;
    assign if_n.write_data = if_b.write_data;
    assign if_n.w_en       = if_b.w_en;
    assign if_n.r1         = if_b.r1;
    assign if_n.r2         = if_b.r2;
    assign if_n.r_en       = if_b.r_en;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n.slave));

    int checks = 0;
    int failures = 0;

    // Reference model: architectural register contents plus a countdown of
    // edges remaining before the array is usable again.
    logic [DW-1:0] mm [DEPTH];
    int            sweep_left;
    logic          m_ready;
    logic [DW-1:0] e1b, e2b, e1n, e2n;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        m_ready = 1'b0;
        e1b = '0; e2b = '0; e1n = '0; e2n = '0;
    endtask

    function automatic logic [DW-1:0] resolve(input logic byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp && if_b.w_en && if_b.rd == a) return if_b.write_data;
        return mm[a];
    endfunction

    task automatic model_edge();
        if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
                m_ready = 1'b1;
            end
        end else if (if_b.clr) begin
            sweep_left = DEPTH;
            m_ready = 1'b0;
        end else begin
            if (if_b.r_en) begin
                e1b = resolve(1'b1, if_b.r1);
                e2b = resolve(1'b1, if_b.r2);
                e1n = resolve(1'b0, if_b.r1);
                e2n = resolve(1'b0, if_b.r2);
            end
            if (if_b.w_en && if_b.rd != 0) mm[if_b.rd] = if_b.write_data;
        end
    endtask

    task automatic check_all();
        chk("ready_byp", {31'd0, if_b.ready}, {31'd0, m_ready});
        chk("ready_nobyp", {31'd0, if_n.ready}, {31'd0, m_ready});
        chk("r1_byp", if_b.r1_read, e1b);
        chk("r2_byp", if_b.r2_read, e2b);
        chk("r1_nobyp", if_n.r1_read, e1n);
        chk("r2_nobyp", if_n.r2_read, e2n);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        if_b.clr = 1'b0; if_b.w_en = 1'b0; if_b.r_en = 1'b0;
        if_b.rd = '0; if_b.write_data = '0; if_b.r1 = '0; if_b.r2 = '0;
    endtask

    task automatic drive(input logic c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        if_b.clr = c; if_b.w_en = we; if_b.rd = a; if_b.write_data = d;
        if_b.r_en = re; if_b.r1 = a1; if_b.r2 = a2;
    endtask

    typedef struct {
        logic          clr;
        logic          w_en;
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
        logic          r_en;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] e1b;
        logic [DW-1:0] e2b;
        logic [DW-1:0] e1n;
        logic [DW-1:0] e2n;
    } vec_t;

    vec_t tbl [9];
    int   first_ready;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[6] = '{1'b0, 1'b1, 5'd5, 32'h11111111, 1'b0, 5'd5, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[7] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 32'h11111111, 32'h0, 32'h11111111, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd31, 32'h0, 32'h0, 32'h0, 32'h0};

        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Initial sweep with idle inputs: ready only after the 32nd edge.
        for (int e = 1; e <= DEPTH; e++) begin
            tick();
            chk("init_sweep_ready", {31'd0, if_b.ready}, {31'd0, (e == DEPTH)});
            chk("init_sweep_r1", if_b.r1_read, 32'h0);
        end

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].clr, tbl[i].w_en, tbl[i].rd, tbl[i].wd, tbl[i].r_en, tbl[i].r1, tbl[i].r2);
            tick();
            chk($sformatf("vec%0d_r1_byp", i), if_b.r1_read, tbl[i].e1b);
            chk($sformatf("vec%0d_r2_byp", i), if_b.r2_read, tbl[i].e2b);
            chk($sformatf("vec%0d_r1_nobyp", i), if_n.r1_read, tbl[i].e1n);
            chk($sformatf("vec%0d_r2_nobyp", i), if_n.r2_read, tbl[i].e2n);
        end

        // Fill 1..31, then clear with a concurrent write to entry 3.
        for (int n = 1; n < DEPTH; n++) begin
            drive(1'b0, 1'b1, AW'(n), 32'hA0 + n, 1'b0, '0, '0);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd30);
        tick();
        chk("fill_r1", if_b.r1_read, 32'hA3);
        chk("fill_r2", if_n.r2_read, 32'hBE);
        drive(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd3, 5'd3);
        tick();
        chk("clr_hold_r1", if_b.r1_read, 32'hA3);
        // Inputs active during the sweep must be ignored.
        for (int e = 1; e <= DEPTH; e++) begin
            drive(1'b0, 1'b1, 5'd3, 32'h5555AAAA, 1'b1, 5'd4, 5'd3);
            tick();
            chk("clr_sweep_ready", {31'd0, if_b.ready}, {31'd0, (e == DEPTH)});
            chk("clr_sweep_hold", if_n.r2_read, 32'hBE);
        end
        idle();
        for (int i = 0; i < DEPTH / 2; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), AW'(i + DEPTH / 2));
            tick();
            chk("cleared_r1", if_n.r1_read, 32'h0);
            chk("cleared_r2", if_n.r2_read, 32'h0);
        end

        // Reset asserted mid-sweep, ten entries in.
        drive(1'b0, 1'b1, 5'd1, 32'hA1, 1'b0, '0, '0);
        tick();
        drive(1'b0, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd1, 5'd2);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd1, 5'd2);
        tick();
        chk("pre_rst_r2", if_b.r2_read, 32'hA2);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        idle();
        repeat (10) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_r1", if_b.r1_read, 32'h0);
        chk("async_rst_r2", if_n.r2_read, 32'h0);
        chk("async_rst_ready", {31'd0, if_b.ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        first_ready = 0;
        for (int e = 1; e <= 40 && first_ready == 0; e++) begin
            tick();
            if (if_b.ready) first_ready = e;
        end
        chk("resweep_len", 32'(first_ready), 32'(DEPTH));

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH - 1));
            drive(($urandom_range(0, 59) == 0), 1'($urandom), a, $urandom, 1'($urandom),
                  ($urandom_range(0, 2) == 0) ? a : AW'($urandom),
                  ($urandom_range(0, 2) == 0) ? a : AW'($urandom));
            tick();
        end

        // clr held high: a fresh sweep each time RUN is re-entered.
        drive(1'b1, 1'b1, 5'd6, 32'h77, 1'b1, 5'd6, 5'd6);
        repeat (3 * DEPTH + 5) tick();
        idle();
        repeat (DEPTH + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the processor's two-read/one-write register file: configurable data width and depth, optional hardwired-zero register, optional write-to-read bypass, and a self-clearing sweep engine that zeroes the array after reset or on request. It sits in the decode stage of the RISC-V core and feeds operand A/B to execute. Storage is a plain array with no reset, so it maps to distributed RAM. All outputs are registered.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read returns pre-write contents
- clk  in  1  single clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  request a full clear sweep (sampled only when ready=1)
- rd  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- w_en  in  1  write enable
- r1  in  ADDR_W  read port 1 address
- r2  in  ADDR_W  read port 2 address
- r_en  in  1  read enable for both ports
- r1_read  out  DATA_W  registered port 1 data
- r2_read  out  DATA_W  registered port 2 data
- ready  out  1  1 = array initialised, accepting reads/writes

## Operation
- State machine, two states: SWEEP, RUN. ready = (state == RUN), registered.
- Reset (rst_n=0, asynchronous): state=SWEEP, sweep counter=0, r1_read=0, r2_read=0, ready=0. Array contents not reset.
- SWEEP: each rising edge writes 0 to mem[cnt], cnt++. On the edge that writes mem[DEPTH-1], state->RUN, cnt->0. w_en, r_en, clr ignored; r1_read/r2_read hold.
- RUN, clr=1: state->SWEEP on that edge; the same cycle's w_en and r_en are dropped; outputs hold.
- RUN, clr=0, w_en=1: mem[rd] <= write_data, except rd==0 with ZERO_REG=1 (dropped).
- RUN, clr=0, r_en=1: rN_read <= value of mem[rN], where value is:
  - 0 if rN==0 and ZERO_REG=1;
  - else write_data if BYPASS=1, w_en=1, rd==rN;
  - else current mem[rN] (pre-write contents).
- r_en=0: r1_read/r2_read hold previous values.
- Both ports may address the same entry; each is resolved independently, no hazard.
- All addresses in range by construction (DEPTH = 2**ADDR_W); no wrap logic.

## Timing
- Read latency 1: data for addresses presented in cycle N is valid after the rising edge ending cycle N.
- Write visible to a non-bypassed read in the following cycle; bypassed read sees it in the same cycle.
- Sweep length: ready rises after exactly DEPTH rising edges following rst_n deassertion, or following the edge that sampled clr. For defaults, 32 edges.
- rst_n asserted mid-sweep or mid-run: immediate return to reset values; sweep restarts from entry 0 on release.
- clr asserted throughout SWEEP: no effect, no sweep extension. clr held high in RUN re-triggers a sweep each time RUN is re-entered.

## Test plan
- Reset release, hold inputs idle -> ready=0 for 31 edges, 1 after edge 32; r1_read=r2_read=0 throughout; then read r1=7, r2=31 -> both 0.
- Write rd=5, data=DEADBEEF, then read r1=5, r2=0 next cycle -> r1_read=DEADBEEF, r2_read=0; write rd=0, data=FFFFFFFF, then read r2=0 -> 0 (ZERO_REG=1).
- Same-cycle write rd=9, data=12345678 with r1=r2=9, r_en=1: BYPASS=1 -> both 12345678; BYPASS=0 (old value 0) -> both 0, next read 12345678.
- r_en=0 while changing r1/r2 and writing rd=r1 -> r1_read/r2_read unchanged; w_en=1, r_en=1 during SWEEP -> write dropped, outputs hold.
- Fill entries 1..31 with 0xA0+n, pulse clr with w_en=1 to rd=3 -> ready low for 32 edges, then all entries read 0, including 3.
- Assert rst_n=0 mid-sweep at cnt=10 -> outputs 0 immediately, ready=0; after release ready rises after a full 32 edges, not 22.
